// File: rtl/decim_fifo_path.sv
// Sample FIFO feeding a power-of-two decimator (pick or block average)
// with a one-deep valid/ready output slot toward the DAC driver.
module decim_fifo_path #(
  parameter int DATAWIDTH   = 14,
  parameter int FIFO_DEPTH  = 64,
  parameter int MAX_DS_LOG2 = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DATAWIDTH-1:0]         wr_data,
  input  logic [2:0]                   ds_log2,
  input  logic                         avg_mode,
  input  logic                         clr_ovf,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [DATAWIDTH-1:0]         out_data,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int ACCW = DATAWIDTH + MAX_DS_LOG2;
  localparam logic [2:0] KMAX = 3'(MAX_DS_LOG2);

  logic [DATAWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic wr_ok;
  logic drop;
  logic rd;
  logic dec_ready;

  logic [DATAWIDTH-1:0] smp_q;
  logic                 smp_vld;
  logic                 consume;

  logic [6:0]           grp_cnt;
  logic [2:0]           k_q;
  logic                 mode_q;
  logic [DATAWIDTH-1:0] pick_q;
  logic [ACCW-1:0]      acc;

  logic                 first;
  logic [2:0]           k_clamp;
  logic [2:0]           k_eff;
  logic                 mode_eff;
  logic [7:0]           grp_last;
  logic                 closes;
  logic                 stall;
  logic [ACCW-1:0]      sum;
  logic [ACCW-1:0]      shifted;
  logic [DATAWIDTH-1:0] result;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign fifo_count = count;

  assign wr_ok = wr_en && !fifo_full;
  assign drop  = wr_en && fifo_full;
  assign rd    = !fifo_empty && dec_ready;

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd)    rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_ok, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Read data register: the sample the decimator works on this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_vld <= 1'b0;
      smp_q   <= '0;
    end else if (rd) begin
      smp_vld <= 1'b1;
      smp_q   <= mem[rd_ptr];
    end else if (consume) begin
      smp_vld <= 1'b0;
    end
  end

  // Group settings come live from the inputs on the first sample only.
  always_comb begin
    k_clamp  = (ds_log2 > KMAX) ? KMAX : ds_log2;
    first    = (grp_cnt == 7'd0);
    k_eff    = first ? k_clamp : k_q;
    mode_eff = first ? avg_mode : mode_q;
    grp_last = (8'd1 << k_eff) - 8'd1;
    closes   = ({1'b0, grp_cnt} == grp_last);
    stall    = smp_vld && closes && out_valid && !out_ready;
    consume  = smp_vld && !stall;
    sum      = (first ? '0 : acc) + ACCW'(smp_q);
    shifted  = sum >> k_eff;
    result   = mode_eff ? shifted[DATAWIDTH-1:0]
                        : (first ? smp_q : pick_q);
  end

  assign dec_ready = !stall;

  // Group counter, latched settings, retained sample and accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grp_cnt <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      pick_q  <= '0;
      acc     <= '0;
    end else if (consume) begin
      grp_cnt <= closes ? 7'd0 : grp_cnt + 7'd1;
      acc     <= sum;
      if (first) begin
        k_q    <= k_eff;
        mode_q <= mode_eff;
        pick_q <= smp_q;
      end
    end
  end

  // Output slot: holds until taken, reloads in the same cycle as a take.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (consume && closes) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decim_fifo_path.sv
// Randomized and directed bench for decim_fifo_path against a
// group-level reference model of the decimated output stream.
module tb_decim_fifo_path;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [13:0] wr_data = '0;
  logic [2:0]  ds_log2 = '0;
  logic        avg_mode = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [13:0] out_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic [6:0]  fifo_count;
  logic        overflow;

  decim_fifo_path dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .ds_log2(ds_log2), .avg_mode(avg_mode), .clr_ovf(clr_ovf),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  bit rnd_rdy = 1'b0;

  int exp_q[$];
  int g_n = 0, g_k = 0, g_first = 0, g_sum = 0;
  bit g_avg = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: each complete group of 2^k written samples gives one
  // output, either its first sample or floor(sum / 2^k).
  task automatic model_push(input int d);
    if (g_n == 0) begin
      g_k     = (ds_log2 > 3'd4) ? 4 : int'(ds_log2);
      g_avg   = avg_mode;
      g_first = d;
      g_sum   = 0;
    end
    g_sum += d;
    g_n++;
    if (g_n == (1 << g_k)) begin
      exp_q.push_back(g_avg ? (g_sum >> g_k) : g_first);
      g_n = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic put(input int d, input bit dropped);
    wr_en   = 1'b1;
    wr_data = 14'(d);
    if (!dropped) model_push(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
    chk(tag, exp_q.size(), 0);
    repeat (4) tick();
  endtask

  logic        hold_p = 1'b0;
  logic [13:0] hold_d = '0;

  // Output monitor: scoreboard on every transfer, stability while stalled.
  always @(negedge clk) begin
    if (rst_n && hold_p)
      chk("hold", {out_valid, out_data}, {1'b1, hold_d});
    hold_p = rst_n && out_valid && !out_ready;
    hold_d = out_data;
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("out_data", out_data, exp_q.pop_front());
    end
  end

  int base;

  initial begin
    repeat (2) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    tick();

    // k=2 pick over a ramp
    ds_log2 = 3'd2; avg_mode = 1'b0; base = n_out;
    for (int i = 0; i < 16; i++) put(i, 0);
    drain("drain_pick");
    chk("pick_pulses", n_out - base, 4);

    // k=2 average, then full-scale average
    avg_mode = 1'b1;
    put(10, 0); put(20, 0); put(30, 0); put(41, 0);
    for (int i = 0; i < 4; i++) put(16383, 0);
    drain("drain_avg");

    // clamp: k=6 behaves as k=4
    ds_log2 = 3'd6;
    for (int i = 0; i < 16; i++) put(1000 + 7 * i, 0);
    drain("drain_clamp");

    // fill with output stalled; two samples escape into the pipeline
    ds_log2 = 3'd0; avg_mode = 1'b0; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 66; i++) put(100 + i, 0);
    tick();
    chk("fill_full", fifo_full, 1);
    chk("fill_count", fifo_count, 64);
    chk("fill_ovf", overflow, 0);
    put(999, 1);
    chk("drop_ovf", overflow, 1);
    chk("drop_count", fifo_count, 64);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);

    // drop while draining starts in the same cycle
    wr_en = 1'b1; wr_data = 14'd777; out_ready = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("race_ovf", overflow, 1);
    chk("race_count", fifo_count, 63);
    drain("drain_fill");

    // mid-group change of k
    ds_log2 = 3'd1; avg_mode = 1'b0; base = n_out;
    put(7, 0);
    repeat (6) tick();
    ds_log2 = 3'd3;
    put(8, 0);
    drain("drain_pair");
    chk("pair_pulses", n_out - base, 1);
    for (int i = 0; i < 7; i++) put(20 + i, 0);
    repeat (8) tick();
    chk("oct_partial", n_out - base, 1);
    put(27, 0);
    drain("drain_oct");
    chk("oct_pulses", n_out - base, 2);

    // reset mid-group (overflow still set from the race)
    ds_log2 = 3'd2; avg_mode = 1'b1;
    put(500, 0); put(600, 0); put(700, 0);
    repeat (6) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    g_n = 0;
    chk("mrst_count", fifo_count, 0);
    chk("mrst_empty", fifo_empty, 1);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ovf", overflow, 0);
    base = n_out;
    for (int i = 0; i < 4; i++) put(40 + i, 0);
    drain("drain_mrst");
    chk("mrst_pulses", n_out - base, 1);

    // randomized phases with random backpressure and write gaps
    for (int p = 0; p < 24; p++) begin
      int k;
      int groups;
      ds_log2  = 3'($urandom_range(0, 7));
      avg_mode = 1'($urandom_range(0, 1));
      k = (ds_log2 > 3'd4) ? 4 : int'(ds_log2);
      groups = $urandom_range(1, 48 >> k);
      rnd_rdy = 1'b1;
      for (int i = 0; i < (groups << k); i++) begin
        put(int'($urandom_range(0, 16383)), 0);
        repeat ($urandom_range(0, 2)) tick();
      end
      drain("drain_rand");
      rnd_rdy = 1'b0;
      out_ready = 1'b1;
      tick();
    end
    chk("final_empty", fifo_empty, 1);
    chk("final_ovf", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
